stream_downsizer: RTL and testbench



---
 rtl/stream_downsizer.sv | 104 ++++++++++
 tb/tb_stream_downsizer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter: one DW_OUT*SCALE word out as SCALE narrow beats.
// Define STREAM_DOWNSIZER_PARTIAL_EN to add s_lanes_i (beats per word minus one).
module stream_downsizer #(
   parameter  int DW_OUT     = 8,
   parameter  int SCALE      = 4,
   parameter  int BIG_ENDIAN = 0,
   localparam int IW         = (SCALE > 1) ? $clog2(SCALE) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DW_OUT*SCALE-1:0] s_data_i,
   input  logic                    s_valid_i,
   input  logic                    s_last_i,
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
   input  logic [IW-1:0]           s_lanes_i,
`endif
   output logic                    s_ready_o,
   output logic [DW_OUT-1:0]       m_data_o,
   output logic                    m_valid_o,
   output logic                    m_last_o,
   input  logic                    m_ready_i
);

   logic [DW_OUT*SCALE-1:0] data_q, data_d;
   logic                    full_q, full_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [IW-1:0]           end_q, end_d;
   logic                    last_q, last_d;
   logic                    rst_blk_q;

   logic                    wr, rd, fin;
   logic [IW-1:0]           word_end;
   logic [DW_OUT-1:0]       lane_w [SCALE];

   for (genvar gi = 0; gi < SCALE; gi++) begin : g_lane
      assign lane_w[gi] = data_q[gi*DW_OUT +: DW_OUT];
   end

`ifdef STREAM_DOWNSIZER_PARTIAL_EN
   // Requests beyond the word width emit the whole word.
   always_comb begin
      word_end = s_lanes_i;
      if (int'(s_lanes_i) >= SCALE) word_end = IW'(SCALE - 1);
   end
`else
   assign word_end = IW'(SCALE - 1);
`endif

   always_comb begin
      data_d    = data_q;
      full_d    = full_q;
      idx_d     = idx_q;
      end_d     = end_q;
      last_d    = last_q;

      fin       = (idx_q == end_q);
      rd        = full_q & m_ready_i;
      s_ready_o = ~rst_blk_q & (~full_q | (rd & fin));
      wr        = s_valid_i & s_ready_o;

      // A new word may load on the same edge the previous final beat leaves.
      if (wr) begin
         data_d = s_data_i;
         last_d = s_last_i;
         idx_d  = '0;
         end_d  = word_end;
         full_d = 1'b1;
      end else if (rd) begin
         if (fin) full_d = 1'b0;
         else     idx_d  = idx_q + 1'b1;
      end
   end

   always_comb begin
      int sel;
      sel = (BIG_ENDIAN != 0) ? (SCALE - 1 - int'(idx_q)) : int'(idx_q);
      m_data_o = '0;
      for (int i = 0; i < SCALE; i++) begin
         if (sel == i) m_data_o = lane_w[i];
      end
   end

   assign m_valid_o = full_q;
   assign m_last_o  = full_q & last_q & fin;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         full_q    <= 1'b0;
         idx_q     <= '0;
         end_q     <= IW'(SCALE - 1);
         last_q    <= 1'b0;
         rst_blk_q <= 1'b1;
      end else begin
         data_q    <= data_d;
         full_q    <= full_d;
         idx_q     <= idx_d;
         end_q     <= end_d;
         last_q    <= last_d;
         rst_blk_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer: little- and big-endian instances share stimulus
// and are compared against a beat-queue model. Honours STREAM_DOWNSIZER_PARTIAL_EN.
module tb_stream_downsizer;
   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_data;
   logic        s_valid, s_last, m_ready;
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
   logic [1:0]  s_lanes;
`endif
   logic        sr0, sr1, mv0, mv1, ml0, ml1;
   logic [7:0]  md0, md1;

   always #5 clk = ~clk;

   stream_downsizer #(.DW_OUT(8), .SCALE(SC), .BIG_ENDIAN(0)) dut_le (
      .clk(clk), .rst(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
      .s_lanes_i(s_lanes),
`endif
      .s_ready_o(sr0), .m_data_o(md0), .m_valid_o(mv0), .m_last_o(ml0), .m_ready_i(m_ready));

   stream_downsizer #(.DW_OUT(8), .SCALE(SC), .BIG_ENDIAN(1)) dut_be (
      .clk(clk), .rst(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
      .s_lanes_i(s_lanes),
`endif
      .s_ready_o(sr1), .m_data_o(md1), .m_valid_o(mv1), .m_last_o(ml1), .m_ready_i(m_ready));

   // Model: a queue of the narrow beats still owed for the word being emitted.
   typedef struct {
      logic [7:0] le;
      logic [7:0] be;
      logic       last;
   } beat_t;
   beat_t q[$];
   bit    blk;
   bit    e_sr, e_mv;
   int    errors = 0;
   int    checks = 0;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        l;
      logic        mr;
      logic        esr;
      logic        emv;
      logic [7:0]  ele;
      logic [7:0]  ebe;
      logic        eml;
   } vec_t;
   vec_t tbl[16];

   function automatic vec_t mk(logic v, logic [31:0] d, logic l, logic mr, logic esr,
                               logic emv, logic [7:0] ele, logic [7:0] ebe, logic eml);
      vec_t r;
      r.v = v; r.d = d; r.l = l; r.mr = mr; r.esr = esr;
      r.emv = emv; r.ele = ele; r.ebe = ebe; r.eml = eml;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int word_beats();
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
      return (int'(s_lanes) >= SC) ? SC : int'(s_lanes) + 1;
`else
      return SC;
`endif
   endfunction

   task automatic model_check();
      e_mv = (q.size() != 0);
      e_sr = !blk && (q.size() == 0 || (q.size() == 1 && m_ready));
      chk("s_ready_le", 32'(sr0), 32'(e_sr));
      chk("s_ready_be", 32'(sr1), 32'(e_sr));
      chk("m_valid_le", 32'(mv0), 32'(e_mv));
      chk("m_valid_be", 32'(mv1), 32'(e_mv));
      if (e_mv) begin
         chk("m_data_le", 32'(md0), 32'(q[0].le));
         chk("m_data_be", 32'(md1), 32'(q[0].be));
         chk("m_last_le", 32'(ml0), 32'(q[0].last));
         chk("m_last_be", 32'(ml1), 32'(q[0].last));
      end else begin
         chk("m_last_idle_le", 32'(ml0), 32'd0);
         chk("m_last_idle_be", 32'(ml1), 32'd0);
      end
   endtask

   task automatic model_update();
      bit wr, rd;
      int n;
      if (rst) begin
         q.delete();
         blk = 1'b1;
      end else begin
         wr = s_valid && e_sr;
         rd = e_mv && m_ready;
         if (rd) void'(q.pop_front());
         if (wr) begin
            beat_t b;
            n = word_beats();
            for (int k = 0; k < n; k++) begin
               b.le   = s_data[8*k +: 8];
               b.be   = s_data[8*(SC-1-k) +: 8];
               b.last = s_last && (k == n - 1);
               q.push_back(b);
            end
            $display("word accepted data=%h last=%0d beats=%0d t=%0t", s_data, s_last, n, $time);
         end
         blk = 1'b0;
      end
   endtask

   task automatic half_chk();
      @(negedge clk);
      model_check();
   endtask

   task automatic edge_upd();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic tick();
      half_chk();
      edge_upd();
   endtask

   initial begin
      rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
      s_lanes = 2'd3;
`endif
      repeat (2) @(posedge clk);
      q.delete();
      blk = 1'b1;
      #1;

      // Reset state
      half_chk();
      chk("rst_m_data_le", 32'(md0), 32'd0);
      chk("rst_m_data_be", 32'(md1), 32'd0);
      edge_upd();
      rst = 1'b0;

      // Single word, then two back-to-back words
      tbl[0]  = mk(1, 32'h44332211, 1, 1, 0, 0, 8'h00, 8'h00, 0);
      tbl[1]  = mk(1, 32'h44332211, 1, 1, 1, 0, 8'h00, 8'h00, 0);
      tbl[2]  = mk(0, 32'h0,        0, 1, 0, 1, 8'h11, 8'h44, 0);
      tbl[3]  = mk(0, 32'h0,        0, 1, 0, 1, 8'h22, 8'h33, 0);
      tbl[4]  = mk(0, 32'h0,        0, 1, 0, 1, 8'h33, 8'h22, 0);
      tbl[5]  = mk(0, 32'h0,        0, 1, 1, 1, 8'h44, 8'h11, 1);
      tbl[6]  = mk(1, 32'h44332211, 0, 1, 1, 0, 8'h00, 8'h00, 0);
      tbl[7]  = mk(1, 32'h88776655, 1, 1, 0, 1, 8'h11, 8'h44, 0);
      tbl[8]  = mk(1, 32'h88776655, 1, 1, 0, 1, 8'h22, 8'h33, 0);
      tbl[9]  = mk(1, 32'h88776655, 1, 1, 0, 1, 8'h33, 8'h22, 0);
      tbl[10] = mk(1, 32'h88776655, 1, 1, 1, 1, 8'h44, 8'h11, 0);
      tbl[11] = mk(0, 32'h0,        0, 1, 0, 1, 8'h55, 8'h88, 0);
      tbl[12] = mk(0, 32'h0,        0, 1, 0, 1, 8'h66, 8'h77, 0);
      tbl[13] = mk(0, 32'h0,        0, 1, 0, 1, 8'h77, 8'h66, 0);
      tbl[14] = mk(0, 32'h0,        0, 1, 1, 1, 8'h88, 8'h55, 1);
      tbl[15] = mk(0, 32'h0,        0, 1, 1, 0, 8'h00, 8'h00, 0);

      for (int i = 0; i < 16; i++) begin
         s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l; m_ready = tbl[i].mr;
         half_chk();
         chk($sformatf("vec%0d_s_ready", i), 32'(sr0), 32'(tbl[i].esr));
         chk($sformatf("vec%0d_m_valid", i), 32'(mv0), 32'(tbl[i].emv));
         chk($sformatf("vec%0d_m_last", i), 32'(ml0), 32'(tbl[i].eml));
         if (tbl[i].emv) begin
            chk($sformatf("vec%0d_data_le", i), 32'(md0), 32'(tbl[i].ele));
            chk($sformatf("vec%0d_data_be", i), 32'(md1), 32'(tbl[i].ebe));
         end else if (i < 2) begin
            chk($sformatf("vec%0d_data_zero", i), 32'(md0), 32'd0);
         end
         edge_upd();
      end

      // Reset after the second beat of a word discards the rest
      s_valid = 1'b1; s_data = 32'hDDCCBBAA; s_last = 1'b0; m_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      half_chk();
      chk("post_rst_valid", 32'(mv0), 32'd0);
      chk("post_rst_ready", 32'(sr0), 32'd0);
      edge_upd();
      s_valid = 1'b1; s_data = 32'h04030201; s_last = 1'b1;
      half_chk();
      chk("post_rst_ready_up", 32'(sr0), 32'd1);
      edge_upd();
      s_valid = 1'b0;
      half_chk();
      chk("post_rst_first_beat", 32'(md0), 32'h01);
      edge_upd();
      repeat (4) tick();

`ifdef STREAM_DOWNSIZER_PARTIAL_EN
      // Partial word: two beats, last on the second
      s_lanes = 2'd1; s_valid = 1'b1; s_data = 32'h44332211; s_last = 1'b1;
      tick();
      s_valid = 1'b0;
      half_chk();
      chk("partial_b0", 32'(md0), 32'h11);
      chk("partial_b0_last", 32'(ml0), 32'd0);
      edge_upd();
      half_chk();
      chk("partial_b1", 32'(md0), 32'h22);
      chk("partial_b1_be", 32'(md1), 32'h33);
      chk("partial_b1_last", 32'(ml0), 32'd1);
      edge_upd();
      half_chk();
      chk("partial_done", 32'(mv0), 32'd0);
      edge_upd();
      s_lanes = 2'd3; s_valid = 1'b1; s_last = 1'b1;
      tick();
      s_valid = 1'b0;
      repeat (5) tick();
`endif

      // Randomised traffic with backpressure and occasional reset
      for (int c = 0; c < 800; c++) begin
         s_valid = ($urandom % 4) != 0;
         s_data  = $urandom;
         s_last  = $urandom % 2;
         m_ready = ($urandom % 3) != 0;
         rst     = ($urandom % 101) == 0;
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
         s_lanes = 2'($urandom % 4);
`endif
         tick();
      end
      rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      repeat (8) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
